// File: rtl/trail_pkg.sv
// trail_pkg: shared types and Johnson trail helpers for the trail monitor
package trail_pkg;

    typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_e;

    localparam int TRAIL_STATES = 12;
    localparam int TRAIL_W      = 6;

    function automatic logic [TRAIL_W-1:0] johnson_succ(input logic [TRAIL_W-1:0] c);
        return {~c[0], c[TRAIL_W-1:1]};
    endfunction

    // Walks the ring from P0 so the code table never has to be typed out.
    function automatic logic [4:0] code_to_phase(input logic [TRAIL_W-1:0] c);
        logic [TRAIL_W-1:0] p;
        logic [4:0] r;
        p = 6'b000001;
        r = '0;
        for (int i = 0; i < TRAIL_STATES; i++) begin
            if (c == p) r = {1'b1, 4'(i)};
            p = johnson_succ(p);
        end
        return r;
    endfunction

endpackage

// File: rtl/trail_monitor_if.sv
// trail_monitor_if: blade input and monitor status bundle
interface trail_monitor_if #(parameter int ERR_W = 8);

    logic [5:0]       blade_in;
    logic [3:0]       phase;
    logic             phase_valid;
    logic             locked;
    logic             step_pulse;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic             stall;

    modport master (
        output blade_in,
        input  phase, phase_valid, locked, step_pulse, err_pulse, err_count, stall
    );

    modport slave (
        input  blade_in,
        output phase, phase_valid, locked, step_pulse, err_pulse, err_count, stall
    );

endinterface

// File: rtl/trail_filter.sv
// trail_filter: synchronises the blade pins and accepts a code once it has been stable
module trail_filter
    import trail_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TRAIL_W-1:0] din,
    output logic [TRAIL_W-1:0] code,
    output logic               accept
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][TRAIL_W-1:0] sync_q, sync_d;
    logic [TRAIL_W-1:0] cand_q, cand_d, acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               acc_vld_q, acc_vld_d;
    logic               same;

    // Counter saturates one past the accept value so the strobe fires only once per run.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], din};
        same      = sync_q[SYNC_STAGES-1] == cand_q;
        cand_d    = same ? cand_q : sync_q[SYNC_STAGES-1];
        cnt_d     = !same ? '0 : (cnt_q == CW'(STABLE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
        accept    = (cnt_q == CW'(STABLE_CYCLES - 1)) && (!acc_vld_q || cand_q != acc_q);
        acc_d     = accept ? cand_q : acc_q;
        acc_vld_d = acc_vld_q | accept;
    end

    // Synchroniser chain and filter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            acc_vld_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            acc_vld_q <= acc_vld_d;
        end
    end

    assign code = cand_q;

endmodule

// File: rtl/trail_monitor.sv
// trail_monitor: checks a sampled blade pattern against the 12-state Johnson trail
module trail_monitor
    import trail_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int LOCK_COUNT    = 3,
    parameter int STALL_CYCLES  = 16777216,
    parameter int ERR_W         = 8
) (
    input logic            clk,
    input logic            rst,
    trail_monitor_if.slave bus
);

    localparam int TW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    logic [TRAIL_W-1:0] code;
    logic               accept;
    logic [4:0]         pk;
    logic               vld, succ;

    state_e             state_q, state_d;
    logic [TRAIL_W-1:0] last_q, last_d;
    logic [3:0]         phase_q, phase_d, good_q, good_d;
    logic               pv_q, pv_d, locked_q, locked_d, step_q, step_d, err_q, err_d;
    logic               stall_q, stall_d;
    logic [ERR_W-1:0]   errcnt_q, errcnt_d;
    logic [TW-1:0]      tmr_q, tmr_d;

    trail_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .din    (bus.blade_in),
        .code   (code),
        .accept (accept)
    );

    // Tracking FSM: classifies each accepted code and runs the stall timer while locked.
    always_comb begin
        pk       = code_to_phase(code);
        vld      = pk[4];
        succ     = vld && code == johnson_succ(last_q);
        state_d  = state_q;
        last_d   = last_q;
        phase_d  = phase_q;
        good_d   = good_q;
        pv_d     = pv_q;
        locked_d = locked_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        stall_d  = stall_q;
        tmr_d    = tmr_q;
        if (accept) begin
            tmr_d = '0;
            if (vld) begin
                stall_d = 1'b0;
                phase_d = pk[3:0];
                last_d  = code;
            end
            case (state_q)
                HUNT: begin
                    pv_d    = vld;
                    good_d  = vld ? 4'd0 : good_q;
                    state_d = vld ? TRACK : HUNT;
                end
                TRACK: begin
                    if (succ) begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == 4'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        good_d  = 4'd0;
                        pv_d    = vld;
                        state_d = vld ? TRACK : HUNT;
                    end
                end
                LOCKED: begin
                    if (succ) begin
                        step_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        good_d   = 4'd0;
                        pv_d     = vld;
                        state_d  = vld ? TRACK : HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q == LOCKED) begin
            if (tmr_q == TW'(STALL_CYCLES - 1)) begin
                stall_d  = 1'b1;
                locked_d = 1'b0;
                state_d  = HUNT;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
        errcnt_d = (err_d && !(&errcnt_q)) ? errcnt_q + 1'b1 : errcnt_q;
    end

    // All tracking state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            last_q   <= '0;
            phase_q  <= '0;
            good_q   <= '0;
            pv_q     <= 1'b0;
            locked_q <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            stall_q  <= 1'b0;
            errcnt_q <= '0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            phase_q  <= phase_d;
            good_q   <= good_d;
            pv_q     <= pv_d;
            locked_q <= locked_d;
            step_q   <= step_d;
            err_q    <= err_d;
            stall_q  <= stall_d;
            errcnt_q <= errcnt_d;
            tmr_q    <= tmr_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_valid = pv_q;
    assign bus.locked      = locked_q;
    assign bus.step_pulse  = step_q;
    assign bus.err_pulse   = err_q;
    assign bus.err_count   = errcnt_q;
    assign bus.stall       = stall_q;

endmodule

// File: tb/tb_trail_monitor.sv
// tb_trail_monitor: randomized and directed checks of trail_monitor against a transaction-level model
module tb_trail_monitor;

    localparam int LAT   = 7;
    localparam int STALL = 64;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    trail_monitor_if #(.ERR_W(8)) bus();

    trail_monitor #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .LOCK_COUNT    (3),
        .STALL_CYCLES  (STALL),
        .ERR_W         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] pcode [12] = '{6'b000001, 6'b000000, 6'b100000, 6'b110000, 6'b111000, 6'b111100,
                               6'b111110, 6'b111111, 6'b011111, 6'b001111, 6'b000111, 6'b000011};

    int         m_mode, m_phase, m_good, m_err, m_since, m_k;
    bit         m_pv, m_locked, m_step, m_errp, m_stall, m_accv, m_ok;
    logic [5:0] m_acc, m_pend;

    function automatic int idx_of(input logic [5:0] c);
        for (int i = 0; i < 12; i++) if (pcode[i] == c) return i;
        return -1;
    endfunction

    function automatic logic [16:0] obs_v();
        return {bus.phase, bus.phase_valid, bus.locked, bus.step_pulse, bus.err_pulse, bus.err_count, bus.stall};
    endfunction

    function automatic logic [16:0] exp_v();
        return {4'(m_phase), m_pv, m_locked, m_step, m_errp, 8'(m_err), m_stall};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_good = 0; m_err = 0; m_since = 0; m_k = 1000;
        m_pv = 0; m_locked = 0; m_step = 0; m_errp = 0; m_stall = 0; m_accv = 0; m_ok = 0;
        m_acc = '0; m_pend = '0;
    endtask

    task automatic model_accept(input logic [5:0] c);
        int i;
        bit v, succ;
        i = idx_of(c);
        v = i >= 0;
        succ = v && i == (m_phase + 1) % 12;
        m_acc = c;
        m_accv = 1;
        if (v) m_stall = 0;
        if (m_mode == 0) begin
            m_pv = v;
            if (v) begin m_phase = i; m_good = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (succ) begin
                m_phase = i;
                m_good++;
                if (m_good == 3) begin m_mode = 2; m_locked = 1; end
            end else begin
                m_errp = 1; m_good = 0; m_pv = v;
                if (v) m_phase = i; else m_mode = 0;
            end
        end else begin
            if (succ) begin
                m_step = 1; m_phase = i;
            end else begin
                m_errp = 1; m_locked = 0; m_good = 0; m_pv = v;
                if (v) begin m_phase = i; m_mode = 1; end else m_mode = 0;
            end
        end
        if (m_errp && m_err < 255) m_err++;
    endtask

    task automatic set_pin(input logic [5:0] c, input int hold);
        bus.blade_in = c;
        m_k = 0;
        m_pend = c;
        m_ok = hold >= LAT && (!m_accv || c != m_acc);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        m_step = 0;
        m_errp = 0;
        m_k++;
        if (m_k == LAT && m_ok) begin
            model_accept(m_pend);
            m_since = 0;
        end else begin
            m_since++;
            if (m_mode == 2 && m_since == STALL) begin
                m_stall = 1; m_locked = 0; m_mode = 0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.blade_in = 6'b000000;
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if (obs_v() !== exp_v()) begin
                bad++;
                $display("FAIL reset got=%h want=%h", obs_v(), exp_v());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_forward();
        for (int i = 0; i < 24; i++) begin
            set_pin(pcode[i % 12], 20);
            for (int k = 0; k < 20; k++) begin
                cyc();
                total++;
                if (obs_v() !== exp_v()) begin
                    bad++;
                    $display("FAIL forward code=%b k=%0d got=%h want=%h", pcode[i % 12], k + 1, obs_v(), exp_v());
                end
            end
        end
        total++;
        if (!(bus.locked === 1'b1 && bus.err_count === 8'd0)) begin
            bad++;
            $display("FAIL forward_end locked=%b err_count=%0d want locked=1 err_count=0", bus.locked, bus.err_count);
        end
    endtask

    task automatic test_jump();
        int seq [9] = '{0, 1, 2, 3, 4, 7, 8, 9, 10};
        for (int i = 0; i < 9; i++) begin
            set_pin(pcode[seq[i]], 20);
            for (int k = 0; k < 20; k++) begin
                cyc();
                total++;
                if (obs_v() !== exp_v()) begin
                    bad++;
                    $display("FAIL jump phase=%0d k=%0d got=%h want=%h", seq[i], k + 1, obs_v(), exp_v());
                end
            end
        end
        total++;
        if (!(bus.locked === 1'b1 && bus.err_count === 8'd1 && bus.phase === 4'd10)) begin
            bad++;
            $display("FAIL jump_end locked=%b err_count=%0d phase=%0d want 1/1/10", bus.locked, bus.err_count, bus.phase);
        end
    endtask

    task automatic test_invalid();
        logic [5:0] seq [2] = '{6'b101010, 6'b100000};
        for (int i = 0; i < 2; i++) begin
            set_pin(seq[i], 20);
            for (int k = 0; k < 20; k++) begin
                cyc();
                total++;
                if (obs_v() !== exp_v()) begin
                    bad++;
                    $display("FAIL invalid code=%b k=%0d got=%h want=%h", seq[i], k + 1, obs_v(), exp_v());
                end
            end
        end
        total++;
        if (!(bus.phase === 4'd2 && bus.phase_valid === 1'b1)) begin
            bad++;
            $display("FAIL invalid_end phase=%0d pv=%b want 2/1", bus.phase, bus.phase_valid);
        end
    endtask

    task automatic test_glitch();
        logic [5:0] seq [5] = '{6'b110000, 6'b111000, 6'b111100, 6'b000000, 6'b111100};
        int hold [5] = '{20, 20, 20, 3, 20};
        for (int i = 0; i < 5; i++) begin
            set_pin(seq[i], hold[i]);
            for (int k = 0; k < hold[i]; k++) begin
                cyc();
                total++;
                if (obs_v() !== exp_v()) begin
                    bad++;
                    $display("FAIL glitch code=%b k=%0d got=%h want=%h", seq[i], k + 1, obs_v(), exp_v());
                end
            end
        end
        total++;
        if (!(bus.phase === 4'd5 && bus.locked === 1'b1)) begin
            bad++;
            $display("FAIL glitch_end phase=%0d locked=%b want 5/1", bus.phase, bus.locked);
        end
    endtask

    task automatic test_stall();
        logic [5:0] seq [2] = '{6'b111110, 6'b111111};
        int hold [2] = '{100, 20};
        for (int i = 0; i < 2; i++) begin
            set_pin(seq[i], hold[i]);
            for (int k = 0; k < hold[i]; k++) begin
                cyc();
                total++;
                if (obs_v() !== exp_v()) begin
                    bad++;
                    $display("FAIL stall code=%b k=%0d got=%h want=%h", seq[i], k + 1, obs_v(), exp_v());
                end
            end
            if (i == 0) begin
                total++;
                if (!(bus.stall === 1'b1 && bus.locked === 1'b0)) begin
                    bad++;
                    $display("FAIL stall_set stall=%b locked=%b want 1/0", bus.stall, bus.locked);
                end
            end
        end
        total++;
        if (bus.stall !== 1'b0) begin
            bad++;
            $display("FAIL stall_clear stall=%b want 0", bus.stall);
        end
    endtask

    task automatic test_random();
        logic [5:0] c;
        int r, h;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            c = r < 6 ? pcode[(m_phase + 1) % 12] : r < 8 ? pcode[$urandom_range(0, 11)] : 6'($urandom);
            h = $urandom_range(8, 20);
            set_pin(c, h);
            for (int k = 0; k < h; k++) begin
                cyc();
                total++;
                if (obs_v() !== exp_v()) begin
                    bad++;
                    $display("FAIL random code=%b k=%0d got=%h want=%h", c, k + 1, obs_v(), exp_v());
                end
            end
        end
    endtask

    task automatic test_err_saturate();
        logic [5:0] c;
        for (int i = 0; i < 302; i++) begin
            c = i[0] ? 6'b111100 : 6'b000001;
            set_pin(c, 8);
            for (int k = 0; k < 8; k++) begin
                cyc();
                total++;
                if (obs_v() !== exp_v()) begin
                    bad++;
                    $display("FAIL errsat code=%b k=%0d got=%h want=%h", c, k + 1, obs_v(), exp_v());
                end
            end
        end
        total++;
        if (bus.err_count !== 8'd255) begin
            bad++;
            $display("FAIL errsat_end err_count=%0d want 255", bus.err_count);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            set_pin(pcode[(m_phase + 1) % 12], 20);
            for (int k = 0; k < 20; k++) cyc();
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (obs_v() !== 17'd0) begin
            bad++;
            $display("FAIL reset_mid got=%h want=0", obs_v());
        end
        rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_forward();
        test_jump();
        test_invalid();
        test_glitch();
        test_stall();
        test_random();
        test_err_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
